// File: rtl/cfg_loop_sequencer.sv
// Configuration-driven nested loop sequencer.
// Captures the loop bounds on start, then walks layer > patch > frame > block > row,
// handing out one index tuple per valid/ready handshake and pulsing done when finished.
module cfg_loop_sequencer #(
  parameter int unsigned LENROW_W = 4,
  parameter int unsigned BLK_W    = 5,
  parameter int unsigned FRAME_W  = 2,
  parameter int unsigned PATCH_W  = 4,
  parameter int unsigned LAYER_W  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [LENROW_W-1:0] CFG_LenRow,
  input  logic [BLK_W-1:0]    CFG_DepBlk,
  input  logic [BLK_W-1:0]    CFG_NumBlk,
  input  logic [FRAME_W-1:0]  CFG_NumFrm,
  input  logic [PATCH_W-1:0]  CFG_NumPat,
  input  logic [LAYER_W-1:0]  CFG_NumLay,
  input  logic                start,
  input  logic                abort,
  input  logic                idx_ready,
  output logic                idx_valid,
  output logic [LENROW_W-1:0] idx_row,
  output logic [BLK_W-1:0]    idx_blk,
  output logic [FRAME_W-1:0]  idx_frm,
  output logic [PATCH_W-1:0]  idx_pat,
  output logic [LAYER_W-1:0]  idx_lay,
  output logic [BLK_W-1:0]    dep_blk,
  output logic                last_row,
  output logic                last_all,
  output logic                busy,
  output logic                done
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]          state_q, state_d;

  // Configuration snapshot, frozen for the whole sequence
  logic [LENROW_W-1:0] lenrow_q, lenrow_d;
  logic [BLK_W-1:0]    depblk_q, depblk_d;
  logic [BLK_W-1:0]    numblk_q, numblk_d;
  logic [FRAME_W-1:0]  numfrm_q, numfrm_d;
  logic [PATCH_W-1:0]  numpat_q, numpat_d;
  logic [LAYER_W-1:0]  numlay_q, numlay_d;

  // Loop counters
  logic [LENROW_W-1:0] row_q, row_d;
  logic [BLK_W-1:0]    blk_q, blk_d;
  logic [FRAME_W-1:0]  frm_q, frm_d;
  logic [PATCH_W-1:0]  pat_q, pat_d;
  logic [LAYER_W-1:0]  lay_q, lay_d;

  logic row_wrap, blk_wrap, frm_wrap, pat_wrap, lay_wrap;
  logic at_end, running, handshake;

  // Each level wraps when it reaches its latched bound
  assign row_wrap  = (row_q == lenrow_q);
  assign blk_wrap  = (blk_q == numblk_q);
  assign frm_wrap  = (frm_q == numfrm_q);
  assign pat_wrap  = (pat_q == numpat_q);
  assign lay_wrap  = (lay_q == numlay_q);
  assign at_end    = row_wrap & blk_wrap & frm_wrap & pat_wrap & lay_wrap;
  assign running   = (state_q == StRun);
  assign handshake = running & idx_ready;

  // Next state, configuration capture and carry-chained counter advance
  always_comb begin
    state_d  = state_q;
    lenrow_d = lenrow_q;
    depblk_d = depblk_q;
    numblk_d = numblk_q;
    numfrm_d = numfrm_q;
    numpat_d = numpat_q;
    numlay_d = numlay_q;
    row_d    = row_q;
    blk_d    = blk_q;
    frm_d    = frm_q;
    pat_d    = pat_q;
    lay_d    = lay_q;

    case (state_q)
      StIdle: begin
        // abort has priority over start
        if (start && !abort) begin
          state_d  = StRun;
          lenrow_d = CFG_LenRow;
          depblk_d = CFG_DepBlk;
          numblk_d = CFG_NumBlk;
          numfrm_d = CFG_NumFrm;
          numpat_d = CFG_NumPat;
          numlay_d = CFG_NumLay;
          row_d    = '0;
          blk_d    = '0;
          frm_d    = '0;
          pat_d    = '0;
          lay_d    = '0;
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StIdle;
          row_d   = '0;
          blk_d   = '0;
          frm_d   = '0;
          pat_d   = '0;
          lay_d   = '0;
        end else if (handshake) begin
          row_d = row_wrap ? '0 : row_q + LENROW_W'(1);
          if (row_wrap) begin
            blk_d = blk_wrap ? '0 : blk_q + BLK_W'(1);
          end
          if (row_wrap && blk_wrap) begin
            frm_d = frm_wrap ? '0 : frm_q + FRAME_W'(1);
          end
          if (row_wrap && blk_wrap && frm_wrap) begin
            pat_d = pat_wrap ? '0 : pat_q + PATCH_W'(1);
          end
          if (row_wrap && blk_wrap && frm_wrap && pat_wrap) begin
            lay_d = lay_wrap ? '0 : lay_q + LAYER_W'(1);
          end
          if (at_end) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        // Always leaves after one cycle; an abort here also lands in idle
        state_d = StIdle;
        row_d   = '0;
        blk_d   = '0;
        frm_d   = '0;
        pat_d   = '0;
        lay_d   = '0;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, snapshot and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      lenrow_q <= '0;
      depblk_q <= '0;
      numblk_q <= '0;
      numfrm_q <= '0;
      numpat_q <= '0;
      numlay_q <= '0;
      row_q    <= '0;
      blk_q    <= '0;
      frm_q    <= '0;
      pat_q    <= '0;
      lay_q    <= '0;
    end else begin
      state_q  <= state_d;
      lenrow_q <= lenrow_d;
      depblk_q <= depblk_d;
      numblk_q <= numblk_d;
      numfrm_q <= numfrm_d;
      numpat_q <= numpat_d;
      numlay_q <= numlay_d;
      row_q    <= row_d;
      blk_q    <= blk_d;
      frm_q    <= frm_d;
      pat_q    <= pat_d;
      lay_q    <= lay_d;
    end
  end

  // Outputs decode directly from registered state; no input-to-output paths
  assign idx_valid = running;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign last_row  = running & row_wrap;
  assign last_all  = running & at_end;
  assign idx_row   = row_q;
  assign idx_blk   = blk_q;
  assign idx_frm   = frm_q;
  assign idx_pat   = pat_q;
  assign idx_lay   = lay_q;
  assign dep_blk   = depblk_q;

endmodule
